// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe
// Purpose  : Handshaked RV immediate generator with a 2-entry skid buffer.
//            Optional CSR-immediate decode enabled by macro ZICSR_IMM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [PC_W-1:0] out_pc
);

  localparam logic [2:0] c_fmt_none  = 3'd0;
  localparam logic [2:0] c_fmt_i     = 3'd1;
  localparam logic [2:0] c_fmt_s     = 3'd2;
  localparam logic [2:0] c_fmt_b     = 3'd3;
  localparam logic [2:0] c_fmt_u     = 3'd4;
  localparam logic [2:0] c_fmt_j     = 3'd5;
  localparam logic [2:0] c_fmt_shamt = 3'd6;
`ifdef ZICSR_IMM_EN
  localparam logic [2:0] c_fmt_csr   = 3'd7;
`endif

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [XLEN-1:0] w_imm;
  logic [2:0]      w_fmt;
  logic            w_ill;
  logic            w_push;
  logic            w_pop;

  logic [XLEN-1:0] r_imm [2];
  logic [2:0]      r_fmt [2];
  logic            r_ill [2];
  logic [PC_W-1:0] r_pc  [2];
  logic [1:0]      r_count;
  logic            r_wr;
  logic            r_rd;

  assign w_opcode = in_inst[6:0];
  assign w_funct3 = in_inst[14:12];

  always_comb begin
    w_imm = '0;
    w_fmt = c_fmt_none;
    w_ill = 1'b0;
    case (w_opcode)
      7'b0000011, 7'b1100111: begin
        w_imm = XLEN'($signed(in_inst[31:20]));
        w_fmt = c_fmt_i;
      end
      7'b0010011: begin
        if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
          // shift amount is 6 bits wide only on RV64
          if (XLEN == 64) w_imm = XLEN'(in_inst[25:20]);
          else            w_imm = XLEN'(in_inst[24:20]);
          w_fmt = c_fmt_shamt;
        end else begin
          w_imm = XLEN'($signed(in_inst[31:20]));
          w_fmt = c_fmt_i;
        end
      end
      7'b0100011: begin
        w_imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
        w_fmt = c_fmt_s;
      end
      7'b1100011: begin
        w_imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
        w_fmt = c_fmt_b;
      end
      7'b1101111: begin
        w_imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
        w_fmt = c_fmt_j;
      end
      7'b0110111, 7'b0010111: begin
        w_imm = XLEN'($signed({in_inst[31:12], 12'b0}));
        w_fmt = c_fmt_u;
      end
      7'b0001111: begin
        w_ill = 1'b0;
      end
`ifdef ZICSR_IMM_EN
      7'b1110011: begin
        if (w_funct3[2]) begin
          w_imm = XLEN'(in_inst[19:15]);
          w_fmt = c_fmt_csr;
        end
      end
`endif
      default: begin
        w_ill = 1'b1;
      end
    endcase
  end

  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= 2'd0;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_imm[i] <= '0;
        r_fmt[i] <= '0;
        r_ill[i] <= 1'b0;
        r_pc[i]  <= '0;
      end
    end else if (flush) begin
      r_count <= 2'd0;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
    end else begin
      if (w_push) begin
        r_imm[r_wr] <= w_imm;
        r_fmt[r_wr] <= w_fmt;
        r_ill[r_wr] <= w_ill;
        r_pc[r_wr]  <= in_pc;
        r_wr        <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // head entry drives the outputs straight from storage
  assign out_imm     = r_imm[r_rd];
  assign out_fmt     = r_fmt[r_rd];
  assign out_illegal = r_ill[r_rd];
  assign out_pc      = r_pc[r_rd];

endmodule
`default_nettype wire
